data_ram_hs: RTL and testbench

Parametrised byte-lane data memory with a valid/ready request channel and a registered response channel, replacing the combinational-read data RAM on the MEM-stage side of the datapath. It supports configurable word width and depth, per-byte write and read masking, out-of-range address detection and back-to-back throughput of one access per cycle with one outstanding response. Memory contents are not reset; all control and output registers are.

---
 rtl/data_ram_hs.sv | 129 ++++++++++++
 tb/tb_data_ram_hs.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_hs.sv
// data_ram_hs: byte-lane data memory behind a valid/ready request channel.
// One request is accepted per cycle and answered by a registered response
// that is held until the consumer takes it; a new request can be accepted
// on the same edge that consumes the previous response.
module data_ram_hs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_sel,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    accept;
    logic                    out_of_range;
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic                    unused_offset_bits;

    // The byte offset inside a word never selects anything: lanes come from req_sel.
    assign unused_offset_bits = ^req_addr[OFF-1:0];
    assign word_idx           = req_addr[DEPTH_LOG2+OFF-1:OFF];

    // Any set bit above the stored word index means the address is outside the array.
    generate
        if (ADDR_WIDTH > DEPTH_LOG2 + OFF) begin : g_range
            assign out_of_range = |req_addr[ADDR_WIDTH-1:DEPTH_LOG2+OFF];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    // Handshake decode: in RESP a new request may only enter when the current response leaves.
    always_comb begin
        next_state = state;
        req_ready  = 1'b1;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                rsp_valid = 1'b0;
                if (req_valid) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                req_ready = rsp_ready;
                rsp_valid = 1'b1;
                if (rsp_ready && !req_valid) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        accept = req_valid && req_ready;
    end

    // State register; reset discards any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Error flag is captured with every accepted request, reads and writes alike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_err <= out_of_range;
        end
    end

    // One independent byte array per lane, so masked writes never touch other lanes.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            logic [7:0] lane_rdata;
            logic       lane_write;
            logic       lane_read;

            assign lane_write = accept && req_we && !out_of_range && req_sel[i];
            assign lane_read  = !req_we && !out_of_range && req_sel[i];

            // Storage is deliberately left unreset.
            always_ff @(posedge clk) begin
                if (lane_write) begin
                    lane_mem[word_idx] <= req_wdata[8*i +: 8];
                end
            end

            // Response byte: stored value for an enabled in-range read, zero otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_rdata <= 8'h00;
                end else if (accept) begin
                    lane_rdata <= lane_read ? lane_mem[word_idx] : 8'h00;
                end
            end

            assign rsp_rdata[8*i +: 8] = lane_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_data_ram_hs.sv
// tb_data_ram_hs: directed and randomized checks of data_ram_hs against a
// byte-addressed reference memory, with a queue-based scoreboard.
module tb_data_ram_hs;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          checkCount;
    int          passCount;
    bit          randomReady;
    logic [32:0] expQ[$];
    logic [32:0] expItem;
    logic [7:0]  modelMem [int];

    data_ram_hs #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH_LOG2(17)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_sel   (req_sel),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Reference: a flat byte memory; 2^17 words of 4 bytes, bits above 18 must be zero.
    task automatic modelAccept(input bit we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
        bit          oor;
        int          word;
        logic [31:0] data;
        oor  = (addr >> 19) != 0;
        word = int'(addr[18:2]);
        data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (!oor && sel[i]) begin
                if (we) modelMem[word*4 + i] = wdata[8*i +: 8];
                else    data[8*i +: 8] = modelMem.exists(word*4 + i) ? modelMem[word*4 + i] : 8'h00;
            end
        end
        expQ.push_back({oor, data});
    endtask

    // Present one request and hold it until the DUT accepts it (bounded).
    task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
        bit accepted;
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_sel   = sel;
        req_wdata = wdata;
        for (int c = 0; c < 100 && !accepted; c++) begin
            if (randomReady) rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (req_ready) begin
                modelAccept(we, addr, sel, wdata);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!accepted) checkOutput("req_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: every response consumed by the bench is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                expItem = expQ.pop_front();
                checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(expItem[31:0]));
                checkOutput("rsp_err", 64'(rsp_err), 64'(expItem[32]));
            end
        end
    end

    initial begin
        bit          we;
        logic [31:0] addr;
        checkCount  = 0;
        passCount   = 0;
        randomReady = 1'b0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h0;
        req_sel     = 4'h0;
        req_wdata   = 32'h0;
        rsp_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Fill words 0..15 so every later read has known contents
        for (int w = 0; w < 16; w++) applyStimulus(1'b1, 32'(w * 4), 4'hF, $urandom);

        // Byte-lane writes and one-cycle read latency
        applyStimulus(1'b1, 32'h10, 4'b1111, 32'h11223344);
        applyStimulus(1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
        applyStimulus(1'b0, 32'h10, 4'b1111, 32'h0);
        checkOutput("lat_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("bytewrite_rdata", 64'(rsp_rdata), 64'h11BB33DD);
        checkOutput("bytewrite_err", 64'(rsp_err), 64'd0);

        // Read mask with ignored low offset bits
        applyStimulus(1'b0, 32'h13, 4'b0011, 32'h0);
        checkOutput("readmask_rdata", 64'(rsp_rdata), 64'h000033DD);

        // Backpressure: a stalled write must not reach the array
        applyStimulus(1'b0, 32'h10, 4'b1111, 32'h0);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_sel   = 4'hF;
        req_wdata = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("bp_rsp_rdata", 64'(rsp_rdata), 64'h11BB33DD);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 32'h10, 4'b0001, 32'h000000AA);
        checkOutput("bp_write_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("bp_write_rdata", 64'(rsp_rdata), 64'd0);
        applyStimulus(1'b0, 32'h10, 4'hF, 32'h0);
        checkOutput("bp_readback", 64'(rsp_rdata), 64'h11BB33AA);

        // Out-of-range write leaves word 0 alone
        applyStimulus(1'b1, 32'h0008_0000, 4'hF, 32'hDEADBEEF);
        checkOutput("oor_err", 64'(rsp_err), 64'd1);
        checkOutput("oor_rdata", 64'(rsp_rdata), 64'd0);
        applyStimulus(1'b0, 32'h0, 4'hF, 32'h0);
        checkOutput("oor_word0_err", 64'(rsp_err), 64'd0);

        // Reset with a response pending
        applyStimulus(1'b0, 32'h4, 4'hF, 32'h0);
        rsp_ready = 1'b0;
        checkOutput("midreset_pre_valid", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 64'(rsp_valid), 64'd0);
        checkOutput("midreset_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("midreset_err", 64'(rsp_err), 64'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 32'h10, 4'hF, 32'h0);
        checkOutput("midreset_readback", 64'(rsp_rdata), 64'h11BB33AA);

        // Randomized traffic with random backpressure and idle gaps
        randomReady = 1'b1;
        for (int n = 0; n < 300; n++) begin
            we   = $urandom_range(0, 1) == 1;
            addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = addr | (32'($urandom_range(1, 8191)) << 19);
            applyStimulus(we, addr, 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        // Drain outstanding responses
        randomReady = 1'b0;
        rsp_ready   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
        checkOutput("drain_rsp_valid", 64'(rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
